// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO pair in EX.
// Build option MULDIV_EARLY_TERM_EN lets multiplies leave CALC once no multiplier bits remain.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_rs,
  input  logic [DATA_WIDTH-1:0] i_rt,
  input  logic                  i_flush,
  input  logic                  i_hilo_read,
  output logic                  o_busy,
  output logic                  o_stall,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic                  o_div_by_zero
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   counter;
  logic            op_div;
  logic            neg_res;
  logic            rem_neg;
  logic            dbz;
  logic [2*DW-1:0] acc;   // mult: running product; div: {remainder, quotient}
  logic [2*DW-1:0] opa;   // mult: shifted multiplicand; div: divisor in the low half
  logic [DW-1:0]   mpl;   // multiplier bits not yet consumed

  logic            start_signed;
  logic            start_dbz;
  logic [DW-1:0]   abs_rs;
  logic [DW-1:0]   abs_rt;
  logic [2*DW-1:0] mult_step;
  logic [2*DW-1:0] div_step;
  logic [2*DW-1:0] acc_step;
  logic [2*DW-1:0] prod;
  logic [DW:0]     div_part;
  logic [DW:0]     div_diff;
  logic            q_bit;
  logic            last_iter;
  logic [DW-1:0]   quo;
  logic [DW-1:0]   rem;
  logic [DW-1:0]   res_hi;
  logic [DW-1:0]   res_lo;

  assign start_signed = ~i_op[0];
  assign start_dbz    = i_op[1] && (i_rt == '0);
  assign abs_rs       = (start_signed && i_rs[DW-1]) ? -i_rs : i_rs;
  assign abs_rt       = (start_signed && i_rt[DW-1]) ? -i_rt : i_rt;

  // Restoring division: a negative trial difference leaves the shifted remainder untouched.
  assign mult_step = acc + (mpl[0] ? opa : '0);
  assign div_part  = {acc[2*DW-1:DW], acc[DW-1]};
  assign div_diff  = div_part - {1'b0, opa[DW-1:0]};
  assign q_bit     = ~div_diff[DW];
  assign div_step  = {q_bit ? div_diff[DW-1:0] : div_part[DW-1:0], acc[DW-2:0], q_bit};
  assign acc_step  = op_div ? div_step : mult_step;

`ifdef MULDIV_EARLY_TERM_EN
  assign last_iter = dbz || (counter == CW'(DW - 1)) || (!op_div && (mpl[DW-1:1] == '0));
`else
  assign last_iter = dbz || (counter == CW'(DW - 1));
`endif

  assign prod = neg_res ? -acc_step : acc_step;
  assign quo  = acc_step[DW-1:0];
  assign rem  = acc_step[2*DW-1:DW];

  // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
  always_comb begin
    res_hi = prod[2*DW-1:DW];
    res_lo = prod[DW-1:0];
    if (dbz) begin
      res_hi = acc[DW-1:0];
      res_lo = '1;
    end else if (op_div) begin
      res_lo = neg_res ? -quo : quo;
      res_hi = rem_neg ? -rem : rem;
    end
  end

  assign o_stall = o_busy & i_hilo_read;

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      counter       <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_hi          <= '0;
      o_lo          <= '0;
      o_div_by_zero <= 1'b0;
      op_div        <= 1'b0;
      neg_res       <= 1'b0;
      rem_neg       <= 1'b0;
      dbz           <= 1'b0;
      acc           <= '0;
      opa           <= '0;
      mpl           <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && !i_flush) begin
            state         <= CALC;
            o_busy        <= 1'b1;
            counter       <= '0;
            o_div_by_zero <= 1'b0;
            op_div        <= i_op[1];
            dbz           <= start_dbz;
            neg_res       <= start_signed && (i_rs[DW-1] ^ i_rt[DW-1]);
            rem_neg       <= start_signed && i_rs[DW-1];
            mpl           <= abs_rt;
            if (i_op[1]) begin
              acc <= {{DW{1'b0}}, start_dbz ? i_rs : abs_rs};
              opa <= {{DW{1'b0}}, abs_rt};
            end else begin
              acc <= '0;
              opa <= {{DW{1'b0}}, abs_rs};
            end
          end
        end
        CALC: begin
          if (i_flush) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            acc     <= acc_step;
            opa     <= op_div ? opa : (opa << 1);
            mpl     <= mpl >> 1;
            counter <= counter + CW'(1);
            if (last_iter) begin
              state  <= DONE;
              o_done <= 1'b1;
              o_hi   <= res_hi;
              o_lo   <= res_lo;
              if (dbz) o_div_by_zero <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes model results, a negedge monitor pops on o_done.
module tb_muldiv_sequencer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic          hilo_read = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [DW-1:0] rs = '0;
  logic [DW-1:0] rt = '0;
  logic          busy, stall, done, dbz;
  logic [DW-1:0] hi, lo;

  muldiv_sequencer #(.DATA_WIDTH(DW)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_op          (op),
    .i_rs          (rs),
    .i_rt          (rt),
    .i_flush       (flush),
    .i_hilo_read   (hilo_read),
    .o_busy        (busy),
    .o_stall       (stall),
    .o_done        (done),
    .o_hi          (hi),
    .o_lo          (lo),
    .o_div_by_zero (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
    int          start;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference results from plain 64-bit arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sd, q, r;
    logic [31:0] m;
    int          msb;
    e.hi = '0; e.lo = '0; e.dbz = 1'b0; e.start = 0;
    case (o)
      2'b00: begin
        p = longint'($signed(a)) * longint'($signed(b));
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      2'b01: begin
        p = {32'h0, a} * {32'h0, b};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      default: begin
        if (b == 32'h0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else if (o == 2'b10) begin
          sa = longint'($signed(a));
          sd = longint'($signed(b));
          q = sa / sd;
          r = sa % sd;
          p = q; e.lo = p[31:0];
          p = r; e.hi = p[31:0];
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    e.lat = (o[1] && b == 32'h0) ? 2 : DW + 1;
`ifdef MULDIV_EARLY_TERM_EN
    if (!o[1]) begin
      m = (o == 2'b00 && b[31]) ? -b : b;
      msb = -1;
      for (int i = 0; i < 32; i++) if (m[i]) msb = i;
      e.lat = 1 + ((msb + 1) < 1 ? 1 : msb + 1);
    end
`else
    m = '0; msb = 0;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", done, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check("hi", hi, mon_e.hi);
        check("lo", lo, mon_e.lo);
        check("div_by_zero", dbz, mon_e.dbz);
        check("latency", cyc - mon_e.start + 1, mon_e.lat);
        check("busy_in_done", busy, 1'b1);
        last_hi = mon_e.hi;
        last_lo = mon_e.lo;
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("op_completes_in_budget", busy, 1'b0);
    hilo_read = 1'b1;
    #1;
    check("no_stall_when_idle", stall, 1'b0);
    hilo_read = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
    exp_t e;
    @(negedge clk);
    op = o; rs = a; rt = b; start = 1'b1;
    e = model(o, a, b);
    e.start = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("dbz_cleared_on_start", dbz, 1'b0);
    if (poke) begin
      op = 2'($urandom_range(0, 3)); rs = $urandom; rt = $urandom;
      start = 1'b1; hilo_read = 1'b1;
      #1;
      check("stall_while_busy", stall, 1'b1);
      @(negedge clk);
      start = 1'b0; hilo_read = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    exp_t        e;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_dbz", dbz, 1'b0);
    rst = 1'b0;

    run_op(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'h0000_1234, 32'h0, 1'b1);
    check("dbz_sticky_idle", dbz, 1'b1);
    run_op(2'b01, 32'h0001_2345, 32'd3, 1'b0);
    run_op(2'b00, 32'h1357_9BDF, 32'h0, 1'b0);

    // Flush during DONE is ignored; stall still covers the DONE cycle.
    @(negedge clk);
    op = 2'b11; rs = 32'h55; rt = 32'h0; start = 1'b1;
    e = model(2'b11, 32'h55, 32'h0);
    e.start = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("done_pulse_dbz", done, 1'b1);
    flush = 1'b1; hilo_read = 1'b1;
    #1;
    check("stall_in_done", stall, 1'b1);
    @(negedge clk);
    flush = 1'b0; hilo_read = 1'b0;
    check("idle_after_done", busy, 1'b0);
    check("dbz_sticky_after_flush_in_done", dbz, 1'b1);

    // Flush mid-CALC: no result, HI/LO untouched.
    @(negedge clk);
    op = 2'b00; rs = $urandom; rt = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_abort_idle", busy, 1'b0);
    repeat (40) @(negedge clk);
    check("flush_hi_kept", hi, last_hi);
    check("flush_lo_kept", lo, last_lo);
    check("dbz_cleared_by_flushed_start", dbz, 1'b0);

    // Start together with flush in IDLE is dropped.
    @(negedge clk);
    op = 2'b11; rs = 32'h9; rt = 32'h0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_dropped_with_flush", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("dropped_start_no_dbz", dbz, 1'b0);

    // Async reset in the middle of CALC.
    run_op(2'b10, 32'hABCD_0001, 32'h0, 1'b0);
    @(negedge clk);
    op = 2'b01; rs = $urandom; rt = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_done", done, 1'b0);
    check("async_reset_hi", hi, 32'h0);
    check("async_reset_lo", lo, 32'h0);
    check("async_reset_dbz", dbz, 1'b0);
    check("async_reset_stall", stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    last_hi = '0; last_lo = '0;

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
